// File: rtl/serial_link_bringup_ctrl.sv
// rtl/serial_link_bringup_ctrl.sv - serial link bring-up/teardown register sequencer
// Walks a fixed CTRL/allocator write list, settles, then polls ISOLATED with gap and timeout.
module serial_link_bringup_ctrl #(
    parameter int unsigned                RegAddrWidth   = 32,
    parameter int unsigned                RegDataWidth   = 32,
    parameter logic [RegAddrWidth-1:0]    CtrlOffset     = RegAddrWidth'(32'h00),
    parameter logic [RegAddrWidth-1:0]    AllocTxOffset  = RegAddrWidth'(32'h08),
    parameter logic [RegAddrWidth-1:0]    AllocRxOffset  = RegAddrWidth'(32'h0C),
    parameter logic [RegAddrWidth-1:0]    IsolatedOffset = RegAddrWidth'(32'h04),
    parameter logic [RegDataWidth-1:0]    AllocCfg       = RegDataWidth'(32'h3),
    parameter int unsigned                SettleCycles   = 50,
    parameter int unsigned                PollGap        = 4,
    parameter int unsigned                MaxPolls       = 256
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          start_i,
    input  logic                          teardown_i,
    output logic [RegAddrWidth-1:0]       cfg_req_addr_o,
    output logic                          cfg_req_write_o,
    output logic [RegDataWidth-1:0]       cfg_req_wdata_o,
    output logic [(RegDataWidth+7)/8-1:0] cfg_req_wstrb_o,
    output logic                          cfg_req_valid_o,
    input  logic [RegDataWidth-1:0]       cfg_rsp_rdata_i,
    input  logic                          cfg_rsp_error_i,
    input  logic                          cfg_rsp_ready_i,
    output logic                          busy_o,
    output logic                          link_up_o,
    output logic                          error_o
);

    localparam int unsigned StrbW  = (RegDataWidth + 7) / 8;
    localparam int unsigned PollW  = $clog2(MaxPolls + 1);
    localparam int unsigned CntMax = (SettleCycles > PollGap) ? SettleCycles : PollGap;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    localparam logic [RegDataWidth-1:0] CtrlIsoRst = RegDataWidth'(32'h300);
    localparam logic [RegDataWidth-1:0] CtrlIsoClk = RegDataWidth'(32'h302);
    localparam logic [RegDataWidth-1:0] CtrlIsoRun = RegDataWidth'(32'h303);
    localparam logic [RegDataWidth-1:0] CtrlRun    = RegDataWidth'(32'h003);

    // Index into the combined bring-up (0..5) and teardown (6..7) write lists
    localparam logic [2:0] StepCtrlIso = 3'd0;
    localparam logic [2:0] StepCtrlClk = 3'd1;
    localparam logic [2:0] StepCtrlRun = 3'd2;
    localparam logic [2:0] StepAllocTx = 3'd3;
    localparam logic [2:0] StepAllocRx = 3'd4;
    localparam logic [2:0] StepDeiso   = 3'd5;
    localparam logic [2:0] StepTdIso   = 3'd6;
    localparam logic [2:0] StepTdRst   = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_SETTLE, S_POLL_RD, S_POLL_GAP, S_UP, S_ERR
    } state_e;

    state_e                  state_q, state_d;
    logic [2:0]              step_q, step_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [PollW-1:0]        poll_q, poll_d;
    logic                    tear_q, tear_d;

    logic [RegAddrWidth-1:0] addr_q, addr_d;
    logic                    write_q, write_d;
    logic [RegDataWidth-1:0] wdata_q, wdata_d;
    logic [StrbW-1:0]        wstrb_q, wstrb_d;
    logic                    valid_q, valid_d;
    logic                    busy_q, busy_d;
    logic                    link_up_q, link_up_d;
    logic                    error_q, error_d;

    logic                    poll_match;
    logic [PollW-1:0]        poll_inc;
    logic                    rdata_unused;

    assign rdata_unused = ^cfg_rsp_rdata_i[RegDataWidth-1:2];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            step_q    <= StepCtrlIso;
            cnt_q     <= '0;
            poll_q    <= '0;
            tear_q    <= 1'b0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            link_up_q <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            cnt_q     <= cnt_d;
            poll_q    <= poll_d;
            tear_q    <= tear_d;
            addr_q    <= addr_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            link_up_q <= link_up_d;
            error_q   <= error_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        cnt_d      = cnt_q;
        poll_d     = poll_q;
        tear_d     = tear_q;
        poll_inc   = poll_q + 1'b1;
        // Bring-up waits for all ports de-isolated, teardown for both isolated
        poll_match = tear_q ? (cfg_rsp_rdata_i[1:0] == 2'b11) : (cfg_rsp_rdata_i[1:0] == 2'b00);
        case (state_q)
            S_IDLE, S_ERR: begin
                if (start_i) begin
                    state_d = S_WRITE;
                    step_d  = StepCtrlIso;
                    tear_d  = 1'b0;
                end
            end
            S_UP: begin
                if (teardown_i) begin
                    state_d = S_WRITE;
                    step_d  = StepTdIso;
                    tear_d  = 1'b1;
                end
            end
            S_WRITE: begin
                if (cfg_rsp_ready_i) begin
                    if (cfg_rsp_error_i) begin
                        state_d = S_ERR;
                    end else begin
                        case (step_q)
                            StepAllocRx: begin
                                state_d = S_SETTLE;
                                cnt_d   = '0;
                            end
                            StepDeiso, StepTdIso: begin
                                state_d = S_POLL_RD;
                                poll_d  = '0;
                            end
                            StepTdRst: state_d = S_IDLE;
                            default:   step_d  = step_q + 3'd1;
                        endcase
                    end
                end
            end
            S_SETTLE: begin
                if (cnt_q == CntW'(SettleCycles - 1)) begin
                    state_d = S_WRITE;
                    step_d  = StepDeiso;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_POLL_RD: begin
                if (cfg_rsp_ready_i) begin
                    if (cfg_rsp_error_i) begin
                        state_d = S_ERR;
                    end else if (poll_match) begin
                        if (tear_q) begin
                            state_d = S_WRITE;
                            step_d  = StepTdRst;
                        end else begin
                            state_d = S_UP;
                        end
                    end else if (poll_inc == PollW'(MaxPolls)) begin
                        state_d = S_ERR;
                    end else begin
                        poll_d = poll_inc;
                        if (PollGap != 0) begin
                            state_d = S_POLL_GAP;
                            cnt_d   = '0;
                        end
                    end
                end
            end
            S_POLL_GAP: begin
                if (cnt_q == CntW'(PollGap - 1)) begin
                    state_d = S_POLL_RD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they can be registered without lag
    always_comb begin
        addr_d    = '0;
        wdata_d   = '0;
        wstrb_d   = '0;
        write_d   = (state_d == S_WRITE);
        valid_d   = (state_d == S_WRITE) || (state_d == S_POLL_RD);
        busy_d    = !(state_d inside {S_IDLE, S_UP, S_ERR});
        link_up_d = (state_d == S_UP);
        error_d   = (state_d == S_ERR);
        if (state_d == S_POLL_RD) begin
            addr_d = IsolatedOffset;
        end else if (state_d == S_WRITE) begin
            wstrb_d = '1;
            addr_d  = CtrlOffset;
            case (step_d)
                StepCtrlIso, StepTdRst: wdata_d = CtrlIsoRst;
                StepCtrlClk:            wdata_d = CtrlIsoClk;
                StepCtrlRun, StepTdIso: wdata_d = CtrlIsoRun;
                StepAllocTx: begin
                    addr_d  = AllocTxOffset;
                    wdata_d = AllocCfg;
                end
                StepAllocRx: begin
                    addr_d  = AllocRxOffset;
                    wdata_d = AllocCfg;
                end
                StepDeiso:              wdata_d = CtrlRun;
            endcase
        end
    end

    assign cfg_req_addr_o  = addr_q;
    assign cfg_req_write_o = write_q;
    assign cfg_req_wdata_o = wdata_q;
    assign cfg_req_wstrb_o = wstrb_q;
    assign cfg_req_valid_o = valid_q;
    assign busy_o          = busy_q;
    assign link_up_o       = link_up_q;
    assign error_o         = error_q;

endmodule

// File: doc/serial_link_bringup_ctrl.md
# serial_link_bringup_ctrl

Hardware sequencer that performs serial-link bring-up and teardown over the link's configuration register bus, replacing software-driven register sequences. It sits between the SoC control logic (start/teardown pulses, status) and the `cfg_req_i`/`cfg_rsp_o` port of one serial link instance. Settle time, poll limits and channel-allocator configuration are parametrised. Polling includes timeout detection, and the block supports an orderly teardown that re-isolates the AXI ports.

## Interface
- `cfg_req_t`, —, register-bus request struct: addr, write, wdata, wstrb, valid.
- `cfg_rsp_t`, —, register-bus response struct: rdata, error, ready.
- `RegAddrWidth`, 32, cfg address width.
- `RegDataWidth`, 32, cfg data width (≥ 10).
- `CtrlOffset`, `SERIAL_LINK_CTRL_OFFSET`, CTRL register address.
- `AllocTxOffset`, `SERIAL_LINK_CHANNEL_ALLOC_TX_CFG_OFFSET`, TX allocator config address.
- `AllocRxOffset`, `SERIAL_LINK_CHANNEL_ALLOC_RX_CFG_OFFSET`, RX allocator config address.
- `IsolatedOffset`, `SERIAL_LINK_ISOLATED_OFFSET`, isolation status address.
- `AllocCfg`, 32'h3, value written to both allocator configs.
- `SettleCycles`, 50, idle cycles between allocator config and de-isolation (≥ 1).
- `PollGap`, 4, idle cycles between consecutive ISOLATED reads (≥ 0).
- `MaxPolls`, 256, ISOLATED reads before timeout (≥ 1).

Ports:
- `clk_i`  in  1  clock; all logic is in this single domain.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `start_i`  in  1  single-cycle request to bring the link up.
- `teardown_i`  in  1  single-cycle request to isolate the link and hold it in reset.
- `cfg_req_o`  out  cfg_req_t  register-bus master request.
- `cfg_rsp_i`  in  cfg_rsp_t  register-bus response.
- `busy_o`  out  1  a sequence is in progress.
- `link_up_o`  out  1  bring-up completed; ports de-isolated.
- `error_o`  out  1  bus error or poll timeout; sticky.

## Operation
CTRL bit fields: bit0 clk_ena, bit1 reset_n, bits[9:8] AXI isolate. Strobe is all-ones for every write.

States: IDLE, WRITE, SETTLE, POLL_RD, POLL_GAP, UP, ERR.

Bring-up write list, issued in order:
- CTRL ← 0x300
- CTRL ← 0x302
- CTRL ← 0x303
- ALLOC_TX ← AllocCfg
- ALLOC_RX ← AllocCfg
- SETTLE for SettleCycles
- CTRL ← 0x003
- poll ISOLATED until rdata[1:0] == 0 → UP

Teardown list:
- CTRL ← 0x303
- poll ISOLATED until rdata[1:0] == 2'b11
- CTRL ← 0x300 → IDLE

Transitions:
- IDLE: `start_i` begins bring-up.
- ERR: `start_i` clears `error_o` and restarts bring-up at step 1.
- UP: `teardown_i` begins teardown.
- `teardown_i` in IDLE or ERR is ignored.
- `start_i` or `teardown_i` while `busy_o` is high is ignored.
- Both asserted in the same cycle: in UP, teardown wins; in IDLE or ERR, start wins.
- Any access completing with `error` = 1, or MaxPolls reads without a match → ERR. Enter ERR with `error_o` = 1, `link_up_o` = 0, and no further accesses.
- Poll counter width is $clog2(MaxPolls+1). It resets at the start of each poll phase and never wraps; reaching MaxPolls triggers ERR.

## Timing
- Reset values: `cfg_req_o` all-zero (valid 0), `busy_o` 0, `link_up_o` 0, `error_o` 0, state IDLE.
- All outputs are registered. `cfg_req_o.valid` rises in the cycle after `start_i`/`teardown_i` is sampled. `busy_o` rises in that same cycle.
- Handshake: once valid is asserted, addr, write, wdata and wstrb stay stable until the cycle with `ready` = 1. rdata and error are sampled in that cycle.
- Back-to-back accesses: after an access completes, the next valid asserts in the following cycle (no gap).
- SETTLE: valid is low for exactly SettleCycles cycles after ALLOC_RX completes.
- POLL_GAP: valid is low for exactly PollGap cycles between reads. PollGap = 0 gives back-to-back reads.
- With zero-wait responses, bring-up with a first-read match takes 7 accesses + SettleCycles. Exact cycle count: 1 + 7 + SettleCycles from `start_i`. `link_up_o` and `busy_o` change in the cycle after the final read completes.
- `link_up_o` drops in the first cycle of teardown.
- Asynchronous reset mid-sequence drops valid immediately, regardless of handshake state, and returns all outputs to reset values.

## Test plan
- Zero-wait slave, ISOLATED reads 0 on first poll, `start_i` pulse:
  - Exact address/data order 0x300, 0x302, 0x303, 3, 3, 0x003, then one read.
  - 50 valid-low cycles before the 0x003 write.
  - `link_up_o` = 1 at cycle 58 after start.
- Random 0–20 cycle `ready` delays:
  - Fields stay stable while valid && !ready.
  - Sequence order unchanged.
  - `busy_o` high throughout.
- ISOLATED returns 0x3, 0x1, then 0x0 with PollGap = 4:
  - Three reads, each separated by 4 idle cycles.
  - Link reaches UP.
- ISOLATED stuck at 0x1 with MaxPolls = 8:
  - Exactly 8 reads, then `error_o` = 1, `busy_o` = 0, no further valid.
  - A following `start_i` restarts at CTRL ← 0x300 with `error_o` cleared.
- `error` = 1 on the ALLOC_TX write → ERR. The ALLOC_RX write is never issued.
- In UP, assert `teardown_i` and `start_i` together:
  - Teardown runs: CTRL ← 0x303, poll until 0x3, CTRL ← 0x300 → IDLE.
- Repeat bring-up, asserting `rst_ni` low mid-SETTLE → all outputs reset within the same cycle.
